// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: synchronizes the device clock and data, decodes 11-bit frames,
// folds E0/F0 prefixes into scan codes and hands them out over a valid/ack handshake.
module ps2_rx_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ack,
    output logic [15:0] key_code,
    output logic        key_break,
    output logic        key_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_last_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [15:0]     code_q, code_d;
    logic            brk_out_q, brk_out_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic            fall;
    logic            din;
    logic            timeout;
    logic            byte_good;
    logic            complete;

    assign fall    = clk_last_q & ~clk_sync_q[1];
    assign din     = data_sync_q[1];
    assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == ToW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        code_d    = code_q;
        brk_out_d = brk_out_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_good = 1'b0;
        complete  = 1'b0;

        if ((state_q == StIdle) || fall) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end

        if (timeout) begin
            state_d  = StIdle;
            to_cnt_d = '0;
            ferr_d   = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!din) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                StData: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = din;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (din && ((^shift_q) ^ parity_q)) begin
                        byte_good = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                end
            endcase
        end

        if (byte_good) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                complete = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end

        // A completing code may replace the held one only when it is being accepted now.
        if (complete) begin
            if (!valid_q || ack) begin
                code_d    = {(ext_q ? 8'hE0 : 8'h00), shift_q};
                brk_out_d = brk_q;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_last_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            code_q      <= '0;
            brk_out_q   <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_last_q  <= clk_sync_q[1];
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            code_q      <= code_d;
            brk_out_q   <= brk_out_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign key_code  = code_q;
    assign key_break = brk_out_q;
    assign key_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed self-checking bench for ps2_rx_ctrl: frames are bit-banged on ps2_clk/ps2_data
// and outputs are sampled on the falling system clock edge or #1 after the rising one.
module tb_ps2_rx_ctrl;

    localparam int unsigned TO = 300;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic        ack;
    logic [15:0] key_code;
    logic        key_break;
    logic        key_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ack       (ack),
        .key_code  (key_code),
        .key_break (key_break),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_val,
                              input int nbits);
        logic [10:0] fr;
        fr = {stop_val, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ack      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_code, key_break, key_valid, frame_err, overrun, busy} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got code=%h brk=%b kv=%b fe=%b ov=%b busy=%b, want all 0",
                     key_code, key_break, key_valid, frame_err, overrun, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got kv=%b want 0", key_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_onset: got kv=%b want 1", key_valid);
        end
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({key_valid, key_code, key_break} !== {1'b1, 16'h001C, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: got kv=%b code=%h brk=%b want 1 001c 0",
                     key_valid, key_code, key_break);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: got kv=%b want 0", key_valid);
        end
        @(negedge clk);
        ack = 1'b0;
        do_ack();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: got kv=%b want 0", key_valid);
        end
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL f0_prefix_kv: got %b want 0", key_valid);
        end
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        checks++;
        if ({key_valid, key_code, key_break} !== {1'b1, 16'h001C, 1'b1}) begin
            errors++;
            $display("FAIL break_1c: got kv=%b code=%h brk=%b want 1 001c 1",
                     key_valid, key_code, key_break);
        end
        do_ack();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL e0f0_prefix_kv: got %b want 0", key_valid);
        end
        send_frame(8'h74, 1'b0, 1'b1, 11);
        checks++;
        if ({key_valid, key_code, key_break} !== {1'b1, 16'hE074, 1'b1}) begin
            errors++;
            $display("FAIL ext_break_74: got kv=%b code=%h brk=%b want 1 e074 1",
                     key_valid, key_code, key_break);
        end
        do_ack();
    endtask

    task automatic test_errors();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        checks++;
        if ((fe_cnt - fe0) !== 1 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_parity: got fe_pulses=%0d kv=%b want 1 0", fe_cnt - fe0, key_valid);
        end
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        checks++;
        if ((fe_cnt - fe0) !== 1 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_stop: got fe_pulses=%0d kv=%b want 1 0", fe_cnt - fe0, key_valid);
        end
        fe0 = fe_cnt;
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ((fe_cnt - fe0) !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_start: got fe_pulses=%0d busy=%b want 1 0", fe_cnt - fe0, busy);
        end
        send_frame(8'h29, 1'b0, 1'b1, 11);
        checks++;
        if ({key_valid, key_code, key_break} !== {1'b1, 16'h0029, 1'b0}) begin
            errors++;
            $display("FAIL after_err_29: got kv=%b code=%h brk=%b want 1 0029 0",
                     key_valid, key_code, key_break);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 6);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_before: got %b want 1", busy);
        end
        repeat (TO + 20) @(negedge clk);
        checks++;
        if ((fe_cnt - fe0) !== 1 || busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got fe_pulses=%0d busy=%b kv=%b want 1 0 0",
                     fe_cnt - fe0, busy, key_valid);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        checks++;
        if ({key_valid, key_code} !== {1'b1, 16'h005A}) begin
            errors++;
            $display("FAIL after_timeout_5a: got kv=%b code=%h want 1 005a", key_valid, key_code);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = ov_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        checks++;
        if ((ov_cnt - ov0) !== 1 || key_valid !== 1'b1 || key_code !== 16'h001C) begin
            errors++;
            $display("FAIL overrun_drop: got ov_pulses=%0d kv=%b code=%h want 1 1 001c",
                     ov_cnt - ov0, key_valid, key_code);
        end
        ov0 = ov_cnt;
        send_frame(8'h29, 1'b0, 1'b1, 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (key_valid !== 1'b1 || key_code !== 16'h0029) begin
            errors++;
            $display("FAIL ack_collide_load: got kv=%b code=%h want 1 0029", key_valid, key_code);
        end
        @(negedge clk);
        ack = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ((ov_cnt - ov0) !== 0 || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_collide_no_ov: got ov_pulses=%0d kv=%b want 0 1",
                     ov_cnt - ov0, key_valid);
        end
        // Leave this code pending so the reset test can see it cleared.
    endtask

    task automatic test_mid_reset();
        int fe0;
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h33, 1'b0, 1'b1, 5);
        fe0 = fe_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({key_code, key_break, key_valid, frame_err, overrun, busy} !== 21'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got code=%h brk=%b kv=%b fe=%b ov=%b busy=%b",
                     key_code, key_break, key_valid, frame_err, overrun, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ((fe_cnt - fe0) !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_fe: got fe_pulses=%0d want 0", fe_cnt - fe0);
        end
        send_frame(8'h74, 1'b0, 1'b1, 11);
        checks++;
        if ({key_valid, key_code, key_break} !== {1'b1, 16'h0074, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_74: got kv=%b code=%h brk=%b want 1 0074 0",
                     key_valid, key_code, key_break);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_break();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the number of clk cycles without a ps2_clk falling edge after which an in-progress frame is aborted.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 device clock.
REQ-005 The block SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 device data.
REQ-006 The block SHALL have port ack, input, 1 bit: consumer accepts the current key_code.
REQ-007 The block SHALL have port key_code, output, 16 bits: {prefix byte (8'hE0 or 8'h00), scan byte}.
REQ-008 The block SHALL have port key_break, output, 1 bit: high when key_code is a release (F0-prefixed).
REQ-009 The block SHALL have port key_valid, output, 1 bit: key_code/key_break hold a pending code.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on start/parity/stop error or timeout.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed code is dropped.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the frame FSM is not IDLE.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized ps2_clk was 1 last cycle and is 0 this cycle.
REQ-014 ps2_data SHALL be sampled only on a detected falling edge.
REQ-015 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE: on edge with data=0 (start bit), go to DATA and clear the bit counter; on edge with data=1, stay in IDLE and pulse frame_err.
- DATA: shift in 8 bits LSB first; after the 8th bit, go to PARITY.
- PARITY: capture the parity bit, go to STOP.
- STOP: on edge, the byte is good iff stop=1 and (XOR of 8 data bits ^ parity)=1 (odd parity); return to IDLE either way.
REQ-016 A bad byte SHALL pulse frame_err for one cycle, be discarded, and clear the E0/F0 prefix flags.
REQ-017 A timeout counter SHALL reset on every falling edge and in IDLE; on reaching TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE, pulse frame_err, and clear the prefix flags.
REQ-018 For a good byte, the sequencer SHALL:
- on 8'hE0, set ext;
- on 8'hF0, set brk;
- on any other byte, complete a code with key_code={ext?8'hE0:8'h00, byte} and key_break=brk, then clear ext and brk.
REQ-019 A completed code SHALL be presented with key_valid=1 in the cycle after the stop-bit edge is detected.
REQ-020 Handshake:
- key_valid, key_code and key_break SHALL hold until a cycle with ack=1 and key_valid=1;
- key_valid SHALL be low in the cycle after that acceptance unless a new code loads in the same cycle;
- ack while key_valid=0 SHALL be ignored.
REQ-021 If a code completes while key_valid=1 and ack=0, the new code SHALL be dropped, overrun pulsed for one cycle, and the held code left unchanged.
REQ-022 If a code completes in the same cycle as an accepting ack, the new code SHALL load, key_valid SHALL stay 1, and overrun SHALL not pulse.
REQ-023 Prefix bytes SHALL never assert key_valid.

Reset
REQ-024 When reset_n=0 at a rising clk edge, the block SHALL set:
- FSM to IDLE, bit counter and timeout counter to 0;
- ext and brk to 0, synchronizers to 1;
- key_code=16'h0000, key_break=0, key_valid=0, frame_err=0, overrun=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no frame_err pulse, and the first frame after reset release SHALL decode normally.

Verification
REQ-026 Frame 0x1C with correct parity -> key_valid=1, key_code=16'h001C, key_break=0; hold until ack, then key_valid=0.
REQ-027 Frames F0, 1C -> single code 16'h001C with key_break=1; frames E0, F0, 74 -> key_code=16'hE074 with key_break=1; no key_valid on prefix bytes.
REQ-028 Frame with flipped parity bit, and separately stop=0 -> one frame_err pulse, no key_valid; following good frame 0x29 -> key_code=16'h0029.
REQ-029 Stop ps2_clk after 5 data bits for more than TIMEOUT_CYCLES -> frame_err pulse, busy=0; next good frame decodes.
REQ-030 Two codes with no ack -> first code held, overrun pulse on second; ack coincident with second completion -> second code loaded, no overrun.
REQ-031 reset_n=0 after E0 and 4 bits of next frame -> all outputs at reset values; next frame 0x74 -> key_code=16'h0074, E0 not applied.
